v_ist_retire: RTL

In-order drain side of the vector Instruction Status Table (IST). It holds up to `NO_OF_SLOTS` vector instructions pushed by the sequencer and advances each slot through the stages IS → RO → EX → WR. It hands instructions to the functional units through a valid/ready dispatch port, marks them complete on writeback, and retires them strictly in program order.

---
 rtl/v_ist_retire.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/v_ist_retire.sv
// In-order drain side of the vector Instruction Status Table: enqueue, dispatch, writeback, retire.
// Optional `V_IST_FLUSH_EN` adds a flush input that empties the table in one cycle.
module v_ist_retire #(
  parameter int NO_OF_SLOTS = 8,
  parameter int OP_BITS     = 6,
  parameter int TAG_BITS    = 3
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                enq_valid,
  input  logic [OP_BITS-1:0]  enq_op,
  output logic                enq_ready,
  output logic                disp_valid,
  output logic [OP_BITS-1:0]  disp_op,
  output logic [TAG_BITS-1:0] disp_tag,
  input  logic                disp_ready,
  input  logic                wb_valid,
  input  logic [TAG_BITS-1:0] wb_tag,
  output logic                ret_valid,
  output logic [OP_BITS-1:0]  ret_op,
  output logic [TAG_BITS-1:0] ret_tag,
  output logic [TAG_BITS:0]   count,
  output logic                err
`ifdef V_IST_FLUSH_EN
  ,
  input  logic                flush
`endif
);

  typedef enum logic [2:0] {
    ST_IS = 3'b000,
    ST_RO = 3'b001,
    ST_EX = 3'b010,
    ST_WR = 3'b011
  } stage_e;

  localparam int unsigned       NSLOT = NO_OF_SLOTS;
  localparam logic [TAG_BITS:0] FULL  = (TAG_BITS+1)'(NO_OF_SLOTS);

  logic                vld_q   [NSLOT];
  logic                vld_d   [NSLOT];
  logic [OP_BITS-1:0]  op_q    [NSLOT];
  logic [OP_BITS-1:0]  op_d    [NSLOT];
  stage_e              stage_q [NSLOT];
  stage_e              stage_d [NSLOT];

  logic [TAG_BITS-1:0] head_q, head_d;
  logic [TAG_BITS-1:0] disp_q, disp_d;
  logic [TAG_BITS-1:0] tail_q, tail_d;
  logic [TAG_BITS:0]   count_q, count_d;
  logic                ret_valid_q, ret_valid_d;
  logic [OP_BITS-1:0]  ret_op_q, ret_op_d;
  logic [TAG_BITS-1:0] ret_tag_q, ret_tag_d;
  logic                err_q, err_d;

  logic enq_fire, disp_fire, wb_ok, ret_fire;

  assign enq_ready  = (count_q != FULL);
  assign disp_valid = vld_q[disp_q] && (stage_q[disp_q] == ST_IS);
  assign disp_op    = op_q[disp_q];
  assign disp_tag   = disp_q;
  assign ret_valid  = ret_valid_q;
  assign ret_op     = ret_op_q;
  assign ret_tag    = ret_tag_q;
  assign count      = count_q;
  assign err        = err_q;

  assign enq_fire  = enq_valid && enq_ready;
  assign disp_fire = disp_valid && disp_ready;
  assign wb_ok     = vld_q[wb_tag] && (stage_q[wb_tag] == ST_EX);
  assign ret_fire  = vld_q[head_q] && (stage_q[head_q] == ST_WR);

  always_comb begin
    vld_d       = vld_q;
    op_d        = op_q;
    stage_d     = stage_q;
    head_d      = head_q;
    disp_d      = disp_q;
    tail_d      = tail_q;
    count_d     = count_q;
    ret_valid_d = 1'b0;
    ret_op_d    = ret_op_q;
    ret_tag_d   = ret_tag_q;
    err_d       = err_q;

    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (vld_q[i] && (stage_q[i] == ST_RO)) stage_d[i] = ST_EX;
    end

    // The dispatch, writeback, retire and enqueue slots are always distinct, so update order is free.
    if (disp_fire) begin
      stage_d[disp_q] = ST_RO;
      disp_d          = disp_q + TAG_BITS'(1);
    end

    if (wb_valid) begin
      if (wb_ok) stage_d[wb_tag] = ST_WR;
      else       err_d           = 1'b1;
    end

    if (ret_fire) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + TAG_BITS'(1);
      ret_valid_d   = 1'b1;
      ret_op_d      = op_q[head_q];
      ret_tag_d     = head_q;
    end

    if (enq_fire) begin
      vld_d[tail_q]   = 1'b1;
      op_d[tail_q]    = enq_op;
      stage_d[tail_q] = ST_IS;
      tail_d          = tail_q + TAG_BITS'(1);
    end

    case ({enq_fire, ret_fire})
      2'b10:   count_d = count_q + (TAG_BITS+1)'(1);
      2'b01:   count_d = count_q - (TAG_BITS+1)'(1);
      default: count_d = count_q;
    endcase

`ifdef V_IST_FLUSH_EN
    if (flush) begin
      for (int unsigned i = 0; i < NSLOT; i++) vld_d[i] = 1'b0;
      head_d      = '0;
      disp_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      ret_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        vld_q[i]   <= 1'b0;
        op_q[i]    <= '0;
        stage_q[i] <= ST_IS;
      end
      head_q      <= '0;
      disp_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ret_valid_q <= 1'b0;
      ret_op_q    <= '0;
      ret_tag_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      op_q        <= op_d;
      stage_q     <= stage_d;
      head_q      <= head_d;
      disp_q      <= disp_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ret_valid_q <= ret_valid_d;
      ret_op_q    <= ret_op_d;
      ret_tag_q   <= ret_tag_d;
      err_q       <= err_d;
    end
  end

endmodule
